// File: rtl/ex_mem_pkg.sv
// Shared types and helpers for the EX/MEM pipeline register: skid-buffer state,
// per-lane control record and lane record width.
package ex_mem_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    localparam int CTRL_W = 5;

    typedef struct packed {
        logic lane_vld;
        logic memread;
        logic memtoreg;
        logic memwrite;
        logic regwrite;
    } lane_ctrl_t;

    // Lane record layout, MSB to LSB: {ctrl, rd, store_data, alu_result}
    function automatic int lane_w(input int xlen, input int ra_w);
        return 2 * xlen + ra_w + CTRL_W;
    endfunction

    function automatic lane_ctrl_t pack_ctrl(input logic lane_vld, input logic memread,
                                             input logic memtoreg, input logic memwrite,
                                             input logic regwrite);
        lane_ctrl_t c;
        c.lane_vld = lane_vld;
        c.memread  = memread;
        c.memtoreg = memtoreg;
        c.memwrite = memwrite;
        c.regwrite = regwrite;
        return c;
    endfunction

    function automatic lane_ctrl_t unpack_ctrl(input logic [CTRL_W-1:0] bits);
        return lane_ctrl_t'(bits);
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry skid buffer with synchronous flush; 1-cycle latency, main register drives output.
// Backpressure: o_rdy depends only on registered state (low when both entries are full).
module pipe_skid_buf
    import ex_mem_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_vld,
    output logic             o_rdy,
    input  logic [WIDTH-1:0] i_dat,
    output logic             o_vld,
    input  logic             i_rdy,
    output logic [WIDTH-1:0] o_dat,
    output logic [1:0]       o_occupancy
);

    skid_state_e      r_state;
    skid_state_e      w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_accept;
    logic             w_take;
    logic             w_load_main;
    logic             w_load_skid;
    logic             w_move_skid;
    logic             w_clear_main;

    assign o_rdy       = (r_state != TWO);
    assign o_vld       = (r_state != EMPTY);
    assign o_dat       = r_main;
    assign o_occupancy = r_state;

    assign w_accept = i_vld & o_rdy & ~i_flush;
    assign w_take   = o_vld & i_rdy;

    always_comb begin
        w_state_nxt  = r_state;
        w_load_main  = 1'b0;
        w_load_skid  = 1'b0;
        w_move_skid  = 1'b0;
        w_clear_main = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_load_main = 1'b1;
                    w_state_nxt = ONE;
                end
            end
            ONE: begin
                if (w_accept && w_take) begin
                    w_load_main = 1'b1;
                end else if (w_accept) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = TWO;
                end else if (w_take) begin
                    w_clear_main = 1'b1;
                    w_state_nxt  = EMPTY;
                end
            end
            TWO: begin
                if (w_take) begin
                    w_move_skid = 1'b1;
                    w_state_nxt = ONE;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        if (i_flush) begin
            w_state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Main is zeroed whenever it empties so outputs read 0 with no entry present.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= i_dat;
            end else if (w_move_skid) begin
                r_main <= r_skid;
            end else if (w_clear_main) begin
                r_main <= '0;
            end
            if (w_load_skid) begin
                r_skid <= i_dat;
            end else if (w_move_skid) begin
                r_skid <= '0;
            end
        end
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// Elastic EX/MEM stage register for LANES lanes; 1-cycle latency, full throughput.
// Backpressure: in_ready low only when both skid entries are held; never combinational from out_ready.
module ex_mem_pipe_reg
    import ex_mem_pkg::*;
#(
    parameter int LANES        = 2,
    parameter int XLEN         = 32,
    parameter int RA_W         = 5,
    parameter int DROP_BUBBLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES-1:0]      lane_valid_in,
    input  logic [LANES*XLEN-1:0] alu_result_in,
    input  logic [LANES*XLEN-1:0] store_data_in,
    input  logic [LANES*RA_W-1:0] rd_in,
    input  logic [LANES-1:0]      memread_in,
    input  logic [LANES-1:0]      memtoreg_in,
    input  logic [LANES-1:0]      memwrite_in,
    input  logic [LANES-1:0]      regwrite_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      lane_valid_out,
    output logic [LANES*XLEN-1:0] alu_result_out,
    output logic [LANES*XLEN-1:0] store_data_out,
    output logic [LANES*RA_W-1:0] rd_out,
    output logic [LANES-1:0]      memread_out,
    output logic [LANES-1:0]      memtoreg_out,
    output logic [LANES-1:0]      memwrite_out,
    output logic [LANES-1:0]      regwrite_out,
    output logic [1:0]            occupancy
);

    localparam int LANE_W = lane_w(XLEN, RA_W);
    localparam int REC_W  = LANES * LANE_W;

    logic [REC_W-1:0] w_rec_in;
    logic [REC_W-1:0] w_rec_out;
    logic             w_bubble;
    logic             w_buf_vld;

    // A dropped bubble still sees in_ready, so the handshake completes without storing.
    assign w_bubble  = ~|lane_valid_in;
    assign w_buf_vld = in_valid & ~((DROP_BUBBLES != 0) & w_bubble);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_ctrl_t        w_ctrl_in;
        lane_ctrl_t        w_ctrl_out;
        logic [LANE_W-1:0] w_lane_out;

        assign w_ctrl_in = pack_ctrl(1'b1, memread_in[g], memtoreg_in[g],
                                     memwrite_in[g], regwrite_in[g]);

        assign w_rec_in[g*LANE_W +: LANE_W] = lane_valid_in[g] ?
            {w_ctrl_in, rd_in[g*RA_W +: RA_W], store_data_in[g*XLEN +: XLEN],
             alu_result_in[g*XLEN +: XLEN]} : '0;

        assign w_lane_out = w_rec_out[g*LANE_W +: LANE_W];
        assign w_ctrl_out = unpack_ctrl(w_lane_out[LANE_W-1 -: CTRL_W]);

        assign lane_valid_out[g]              = w_ctrl_out.lane_vld;
        assign memread_out[g]                 = w_ctrl_out.memread;
        assign memtoreg_out[g]                = w_ctrl_out.memtoreg;
        assign memwrite_out[g]                = w_ctrl_out.memwrite;
        assign regwrite_out[g]                = w_ctrl_out.regwrite;
        assign rd_out[g*RA_W +: RA_W]         = w_lane_out[2*XLEN +: RA_W];
        assign store_data_out[g*XLEN +: XLEN] = w_lane_out[XLEN +: XLEN];
        assign alu_result_out[g*XLEN +: XLEN] = w_lane_out[0 +: XLEN];
    end

    pipe_skid_buf #(
        .WIDTH(REC_W)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .i_flush    (flush),
        .i_vld      (w_buf_vld),
        .o_rdy      (in_ready),
        .i_dat      (w_rec_in),
        .o_vld      (out_valid),
        .i_rdy      (out_ready),
        .o_dat      (w_rec_out),
        .o_occupancy(occupancy)
    );

endmodule
